// File: rtl/proc.sv
// -----------------------------------------------------------------------------
// proc : processing element of a systolic ring for matrix-vector products.
//
// Every rising clock edge the PE accumulates a * operand into its accumulator
// and forwards the operand it used to the downstream PE. The first edge after
// reset takes the operand from x_init (ring injection); every later edge takes
// it from x (upstream neighbour).
//
// Build option:
//   PROC_SATURATE_EN  defined   -> accumulator saturates at 2^WIDTH-1 and
//                                  stays there until reset
//                     undefined -> accumulator wraps modulo 2^WIDTH
//
// Ports:
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high reset
//   x       in   WIDTH  operand from upstream PE (2nd edge after reset onward)
//   x_init  in   WIDTH  initial operand (1st edge after reset only)
//   a       in   WIDTH  unsigned coefficient
//   y       out  WIDTH  accumulator value, registered
//   x_out   out  WIDTH  operand used on the last edge, registered
// -----------------------------------------------------------------------------
module proc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] x_init,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x_out
);

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_xr;
    logic               r_first;

    logic [WIDTH-1:0]   w_sel;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH:0]   w_sum;
    logic [WIDTH-1:0]   w_acc_next;

    // Operand select, full-precision multiply-accumulate and result narrowing.
    always_comb begin
        w_sel      = r_first ? x_init : x;
        w_prod     = a * w_sel;
        // Sum is formed one bit wider than the product so no carry is lost
        // before the overflow decision below.
        w_sum      = {{(WIDTH+1){1'b0}}, r_acc} + {1'b0, w_prod};
        w_acc_next = w_sum[WIDTH-1:0];
`ifdef PROC_SATURATE_EN
        // Any set bit above the result width means the true sum exceeds the
        // largest representable value; clamp. Once clamped, any further
        // non-zero product overflows again, so the value sticks until reset.
        if (|w_sum[2*WIDTH:WIDTH]) begin
            w_acc_next = {WIDTH{1'b1}};
        end else begin
            w_acc_next = w_sum[WIDTH-1:0];
        end
`endif
    end

    // State registers: accumulator, forwarded operand and first-cycle flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= {WIDTH{1'b0}};
            r_xr    <= {WIDTH{1'b0}};
            r_first <= 1'b1;
        end else begin
            r_acc   <= w_acc_next;
            r_xr    <= w_sel;
            r_first <= 1'b0;
        end
    end

    assign y     = r_acc;
    assign x_out = r_xr;

endmodule

// File: tb/tb_proc.sv
// -----------------------------------------------------------------------------
// tb_proc : table-driven self-checking bench for the proc processing element.
// Each table row either applies one set of inputs across one clock edge, or
// (rst=1) asserts reset between edges, checks the outputs clear without an
// edge, holds reset across an edge, and releases it again.
// Expected values are hand-computed; saturating-build values are selected
// when PROC_SATURATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_proc;

    localparam int W = 8;

`ifdef PROC_SATURATE_EN
    localparam logic [W-1:0] E_FF1 = 8'hFF;
    localparam logic [W-1:0] E_FF2 = 8'hFF;
    localparam logic [W-1:0] E_FF3 = 8'hFF;
    localparam logic [W-1:0] E_OV1 = 8'hFF;
    localparam logic [W-1:0] E_OV2 = 8'hFF;
`else
    localparam logic [W-1:0] E_FF1 = 8'h01;
    localparam logic [W-1:0] E_FF2 = 8'h02;
    localparam logic [W-1:0] E_FF3 = 8'h03;
    localparam logic [W-1:0] E_OV1 = 8'h2F;
    localparam logic [W-1:0] E_OV2 = 8'h30;
`endif

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] xi;
        logic [W-1:0] x;
        logic [W-1:0] ey;
        logic [W-1:0] exo;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] x;
    logic [W-1:0] x_init;
    logic [W-1:0] a;
    logic [W-1:0] y;
    logic [W-1:0] x_out;

    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    proc #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .x_init (x_init),
        .a      (a),
        .y      (y),
        .x_out  (x_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [W-1:0] av, input logic [W-1:0] xiv,
                       input logic [W-1:0] xv, input logic [W-1:0] ey,
                       input logic [W-1:0] exo);
        vec_t v;
        v.rst = r; v.a = av; v.xi = xiv; v.x = xv; v.ey = ey; v.exo = exo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        a       = 8'h00;
        x       = 8'h00;
        x_init  = 8'h00;

        // Counting with unit operands, then reset and restart.
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01);
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h03, 8'h01);
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h04, 8'h01);
        add(1'b1, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00);
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01);
        // x_init used once, then x.
        add(1'b1, 8'h02, 8'h05, 8'h03, 8'h00, 8'h00);
        add(1'b0, 8'h02, 8'h05, 8'h03, 8'h0A, 8'h05);
        add(1'b0, 8'h02, 8'h05, 8'h03, 8'h10, 8'h03);
        add(1'b0, 8'h02, 8'h05, 8'h03, 8'h16, 8'h03);
        // Maximal operands: wrap or saturate.
        add(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00);
        add(1'b0, 8'hFF, 8'hFF, 8'hFF, E_FF1, 8'hFF);
        add(1'b0, 8'hFF, 8'hFF, 8'hFF, E_FF2, 8'hFF);
        add(1'b0, 8'hFF, 8'hFF, 8'hFF, E_FF3, 8'hFF);
        // Zero coefficient: y holds, x_out still follows the operand.
        add(1'b1, 8'h00, 8'h33, 8'h11, 8'h00, 8'h00);
        add(1'b0, 8'h00, 8'h33, 8'h11, 8'h00, 8'h33);
        add(1'b0, 8'h00, 8'h33, 8'h22, 8'h00, 8'h22);
        add(1'b0, 8'h00, 8'h33, 8'h22, 8'h00, 8'h22);
        // Inputs changing every cycle, x_init equal to x, overflow past 0xFF.
        add(1'b1, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00);
        add(1'b0, 8'h03, 8'h04, 8'h04, 8'h0C, 8'h04);
        add(1'b0, 8'h05, 8'h09, 8'h07, 8'h2F, 8'h07);
        add(1'b0, 8'h10, 8'h09, 8'h10, E_OV1, 8'h10);
        add(1'b0, 8'h01, 8'h09, 8'h01, E_OV2, 8'h01);

        // Reset state from power-up, before any clock edge.
        #3;
        check("por_y", -1, y, 8'h00);
        check("por_xout", -1, x_out, 8'h00);
        // Edges during reset are ignored.
        @(posedge clk);
        @(negedge clk);
        check("hold_y", -1, y, 8'h00);
        check("hold_xout", -1, x_out, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            a      = vecs[i].a;
            x_init = vecs[i].xi;
            x      = vecs[i].x;
            if (vecs[i].rst) begin
                // Asserted between edges: outputs must clear with no edge.
                reset = 1'b1;
                #1;
                check("async_y", i, y, vecs[i].ey);
                check("async_xout", i, x_out, vecs[i].exo);
                @(posedge clk);
                @(negedge clk);
                check("rst_y", i, y, vecs[i].ey);
                check("rst_xout", i, x_out, vecs[i].exo);
                reset = 1'b0;
            end else begin
                @(posedge clk);
                @(negedge clk);
                check("y", i, y, vecs[i].ey);
                check("xout", i, x_out, vecs[i].exo);
            end
        end

        // Inputs changing away from the edge must not reach the outputs.
        a = 8'h77;
        x = 8'h66;
        #2;
        check("nocomb_y", -2, y, E_OV2);
        check("nocomb_xout", -2, x_out, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/proc.md
Name: proc

Overview:
- Processing element (PE) of a systolic ring for matrix-vector products: computes y = sum of a*x(k) over successive clock cycles.
- Each PE holds a coefficient input `a` and receives an operand stream. The first operand after reset comes from `x_init` (ring injection); later operands come from `x`, the upstream neighbour in the ring.
- The operand used each cycle is registered and forwarded on `x_out` to the downstream PE.

Parameters:
- WIDTH, 8, data width of x, x_init, a, y, x_out.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- x  input  WIDTH  operand from upstream PE (used from the 2nd cycle after reset onward)
- x_init  input  WIDTH  initial operand (used on the 1st cycle after reset only)
- a  input  WIDTH  coefficient, unsigned
- y  output  WIDTH  accumulator value, registered
- x_out  output  WIDTH  operand used in the last cycle, registered, for ring forwarding

Interface rules:
- One clock; reset is asynchronous and active-high.
- The ports are named clk and reset.

Behaviour:
- State: accumulator acc[WIDTH-1:0] (drives y), operand register xr[WIDTH-1:0] (drives x_out), 1-bit flag `first`.
- Reset asserted (asynchronous): acc=0, xr=0, first=1. y=0 and x_out=0 immediately.
- While reset is held, all registers stay at their reset values and clock edges are ignored.
- Operand select: sel = first ? x_init : x.
- Each rising clk edge with reset low:
  - acc <= acc + a*sel.
  - xr <= sel.
  - first <= 0.
- Arithmetic: unsigned. The product a*sel is 2*WIDTH bits. The sum is formed at 2*WIDTH+1 bits, then truncated to the low WIDTH bits (modulo 2^WIDTH wrap-around).
- Latency: y reflects the operands sampled at an edge one cycle later; there is no combinational path from the inputs to y or x_out.
- First edge after reset release: uses x_init exactly once, even if x_init equals x.
- Reset mid-operation: acc is discarded and the sequence restarts. The next edge again uses x_init.
- a or x changing every cycle: the value present at the sampling edge is used.
- a=0 or sel=0: acc holds its value; xr still updates.
- The design is free of latches. All state is in flops clocked by clk and asynchronously reset by reset.

Optional Feature:
- Macro: PROC_SATURATE_EN.
- Defined: accumulation saturates. If the full-precision acc + a*sel exceeds 2^WIDTH-1, acc <= 2^WIDTH-1 and stays there until reset.
- Not defined: modulo 2^WIDTH wrap-around as above.
- x_out behaviour is identical in both builds.

Test Plan:
- Reset asserted mid-cycle with no clock edge -> y=0x00 and x_out=0x00 immediately (asynchronous).
- Reset released; a=0x01, x_init=0x01, x=0x01 -> y=1,2,3,4 on four consecutive edges; x_out=0x01.
- a=0x02, x_init=0x05, x=0x03 -> y=0x0A, 0x10, 0x16; x_out=0x05 after the first edge, then 0x03.
- Reset pulsed after y=0x04, inputs unchanged (a=x=x_init=0x01) -> y=0 during reset, then 1,2,... again, using x_init on the first edge.
- a=0xFF, x=x_init=0xFF, 3 edges, without PROC_SATURATE_EN -> y=0x01, 0x02, 0x03.
  - Same stimulus with PROC_SATURATE_EN defined -> y=0xFF and holds.
- a=0x00, x varying 0x11, 0x22 -> y stays 0x00; x_out follows the selected operand (x_init on edge 1, then 0x11, 0x22).
